// File: rtl/fiford_pkg.sv
// Shared types and sizing helpers for the FIFO block reader.
package fiford_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam int DW_DEF    = 32;
  localparam int WORDS_DEF = 34;

  function automatic int wcnt_w(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/fiford_tmo.sv
// Loadable down-counter that flags expiry on the last enabled count.
module fiford_tmo #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TMO);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/fifo_block_reader.sv
// Pops FIFO words one get at a time and packs WORDS of them into a rate block.
// Optional WAIT timeout enabled by defining FIFORD_TMO_EN.
module fifo_block_reader
  import fiford_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int WORDS = WORDS_DEF
`ifdef FIFORD_TMO_EN
  ,
  parameter int TMO   = 15
`endif
) (
  input  logic                       rdclk,
  input  logic                       rdrst,
  input  logic                       fifordy,
  output logic                       fifoget,
  input  logic                       fifovld,
  input  logic [DW-1:0]              fifodout,
  input  logic                       flush,
  output logic [WORDS*DW-1:0]        blk_data,
  output logic                       blk_vld,
  input  logic                       blk_rdy,
  output logic [wcnt_w(WORDS)-1:0]   wcnt,
  output logic                       rderr
);

  localparam int CW = wcnt_w(WORDS);

  state_e                state_q, state_d;
  logic                  fifoget_q, fifoget_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [WORDS*DW-1:0]   blk_q, blk_d;
  logic                  rderr_q, rderr_d;
  logic                  drop_q, drop_d;
  logic                  wr;
  logic                  tmo_exp;

`ifdef FIFORD_TMO_EN
  fiford_tmo #(.TMO(TMO)) u_tmo (
    .clk      (rdclk),
    .rst_n    (rdrst),
    .load_i   (state_q == REQ),
    .en_i     ((state_q == WAIT) && !fifovld),
    .expire_o (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    blk_d   = blk_q;
    rderr_d = rderr_q;
    drop_d  = drop_q;
    wr      = 1'b0;

    // A data beat outside WAIT is either the orphan of an abandoned get or a protocol error.
    if (fifovld && (state_q != WAIT)) begin
      if (drop_q) drop_d  = 1'b0;
      else        rderr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: if (fifordy && !drop_q) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (fifovld) begin
          wr     = 1'b1;
          wcnt_d = (wcnt_q == CW'(WORDS)) ? wcnt_q : wcnt_q + CW'(1);
          if (wcnt_q == CW'(WORDS - 1)) state_d = OUT;
          else if (fifordy)             state_d = REQ;
          else                          state_d = IDLE;
        end else if (tmo_exp) begin
          rderr_d = 1'b1;
          drop_d  = 1'b1;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (blk_rdy) begin
          wcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      wcnt_d  = '0;
      wr      = 1'b0;
      if ((state_q == REQ) || ((state_q == WAIT) && !fifovld)) drop_d = 1'b1;
    end

    if (wr) begin
      for (int k = 0; k < WORDS; k++) begin
        if (wcnt_q == CW'(k)) blk_d[k*DW +: DW] = fifodout;
      end
    end

    fifoget_d = (state_d == REQ);
  end

  always_ff @(posedge rdclk) begin
    if (!rdrst) begin
      state_q   <= IDLE;
      fifoget_q <= 1'b0;
      wcnt_q    <= '0;
      blk_q     <= '0;
      rderr_q   <= 1'b0;
      // A get issued before reset still owes one data beat; swallow it quietly.
      drop_q    <= ((state_q == REQ) || (state_q == WAIT) || drop_q) && !fifovld;
    end else begin
      state_q   <= state_d;
      fifoget_q <= fifoget_d;
      wcnt_q    <= wcnt_d;
      blk_q     <= blk_d;
      rderr_q   <= rderr_d;
      drop_q    <= drop_d;
    end
  end

  assign fifoget  = fifoget_q;
  assign blk_data = blk_q;
  assign blk_vld  = (state_q == OUT);
  assign wcnt     = wcnt_q;
  assign rderr    = rderr_q;

endmodule

// File: tb/tb_fifo_block_reader.sv
// Self-checking bench for fifo_block_reader: FIFO model with configurable latency and a word-stream scoreboard.
module tb_fifo_block_reader;

  localparam int DW    = 32;
  localparam int WORDS = 34;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int BW    = DW * WORDS;

  logic          rdclk = 1'b0;
  logic          rdrst = 1'b0;
  logic          fifordy = 1'b0;
  logic          fifoget;
  logic          fifovld = 1'b0;
  logic [DW-1:0] fifodout = '0;
  logic          flush = 1'b0;
  logic [BW-1:0] blk_data;
  logic          blk_vld;
  logic          blk_rdy = 1'b0;
  logic [CW-1:0] wcnt;
  logic          rderr;

  always #5 rdclk = ~rdclk;

  fifo_block_reader dut (
    .rdclk    (rdclk),
    .rdrst    (rdrst),
    .fifordy  (fifordy),
    .fifoget  (fifoget),
    .fifovld  (fifovld),
    .fifodout (fifodout),
    .flush    (flush),
    .blk_data (blk_data),
    .blk_vld  (blk_vld),
    .blk_rdy  (blk_rdy),
    .wcnt     (wcnt),
    .rderr    (rderr)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            lat = 1;
  int            pend_cnt = 0;
  logic [DW-1:0] pend_word = '0;
  bit            rdy_en = 1'b1;
  bit            no_resp = 1'b0;
  bit            inj_vld = 1'b0;
  logic [DW-1:0] inj_word = '0;
  int            cyc = 0;
  int            get_cnt = 0;
  int            blk_cnt = 0;
  int            vld_cycles = 0;
  int            get_cyc[$];
  logic [BW-1:0] last_blk = '0;

  // One clock of the FIFO model and scoreboard, entered and left at a falling edge.
  task automatic step();
    logic [BW-1:0] exp_blk;
    if (fifoget) begin
      n_chk++;
      if (pend_cnt != 0 || fifovld) begin
        n_fail++;
        $display("FAIL single_outstanding: get at cycle %0d with pending=%0d vld=%0b, required none", cyc, pend_cnt, fifovld);
      end
      n_chk++;
      if (blk_vld) begin
        n_fail++;
        $display("FAIL get_while_blk_vld: fifoget=1 blk_vld=1 at cycle %0d, required fifoget=0", cyc);
      end
      get_cnt++;
      get_cyc.push_back(cyc);
      if (fq.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_underflow: get at cycle %0d with empty FIFO, required fifordy-qualified get", cyc);
        pend_word = '0;
      end else begin
        pend_word = fq.pop_front();
      end
      if (!no_resp) pend_cnt = lat;
    end
    if (blk_vld) vld_cycles++;
    if (blk_vld && blk_rdy && rdrst && !flush) begin
      exp_blk = '0;
      n_chk++;
      if (exp_q.size() < WORDS) begin
        n_fail++;
        $display("FAIL block_expect: block %0d accepted with %0d model words, required %0d", blk_cnt, exp_q.size(), WORDS);
      end else begin
        for (int k = 0; k < WORDS; k++) exp_blk[k*DW +: DW] = exp_q.pop_front();
        if (blk_data !== exp_blk) begin
          n_fail++;
          for (int k = 0; k < WORDS; k++) begin
            if (blk_data[k*DW +: DW] !== exp_blk[k*DW +: DW]) begin
              $display("FAIL block_data: block %0d word %0d got %h, required %h", blk_cnt, k, blk_data[k*DW +: DW], exp_blk[k*DW +: DW]);
              break;
            end
          end
        end
      end
      last_blk = blk_data;
      blk_cnt++;
    end
    @(negedge rdclk);
    cyc++;
    fifovld = 1'b0;
    if (inj_vld) begin
      fifovld  = 1'b1;
      fifodout = inj_word;
      inj_vld  = 1'b0;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        fifovld  = 1'b1;
        fifodout = pend_word;
      end
    end
    fifordy = rdy_en && (fq.size() > 0);
  endtask

  task automatic do_reset(input int n);
    rdrst   = 1'b0;
    flush   = 1'b0;
    blk_rdy = 1'b0;
    inj_vld = 1'b0;
    no_resp = 1'b0;
    repeat (n) step();
    fq.delete();
    exp_q.delete();
    rdy_en  = 1'b1;
    fifordy = 1'b0;
    rdrst   = 1'b1;
  endtask

  task automatic run_until_blocks(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (blk_cnt < target && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    if (blk_cnt < target) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d blocks after %0d cycles, required %0d", name, blk_cnt, budget, target);
    end
  endtask

  task automatic run_until_gets(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (get_cnt < target && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    if (get_cnt < target) begin
      n_fail++;
      $display("FAIL %s_get_timeout: %0d gets after %0d cycles, required %0d", name, get_cnt, budget, target);
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    n_chk++; if (fifoget !== 1'b0) begin n_fail++; $display("FAIL reset_fifoget: got %0b, required 0", fifoget); end
    n_chk++; if (blk_vld !== 1'b0) begin n_fail++; $display("FAIL reset_blk_vld: got %0b, required 0", blk_vld); end
    n_chk++; if (blk_data !== '0) begin n_fail++; $display("FAIL reset_blk_data: got nonzero %h, required 0", blk_data[DW-1:0]); end
    n_chk++; if (wcnt !== '0) begin n_fail++; $display("FAIL reset_wcnt: got %0d, required 0", wcnt); end
    n_chk++; if (rderr !== 1'b0) begin n_fail++; $display("FAIL reset_rderr: got %0b, required 0", rderr); end
  endtask

  task automatic test_full_block();
    int g0, b0, v0;
    do_reset(2);
    lat = 1;
    blk_rdy = 1'b1;
    for (int i = 1; i <= WORDS; i++) begin
      fq.push_back(DW'(i));
      exp_q.push_back(DW'(i));
    end
    fifordy = 1'b1;
    g0 = get_cnt; b0 = blk_cnt; v0 = vld_cycles;
    get_cyc.delete();
    run_until_blocks(b0 + 1, 300, "full_block");
    repeat (3) step();
    n_chk++;
    if (get_cnt - g0 != WORDS) begin n_fail++; $display("FAIL full_get_count: got %0d, required %0d", get_cnt - g0, WORDS); end
    for (int i = 1; i < get_cyc.size(); i++) begin
      n_chk++;
      if (get_cyc[i] - get_cyc[i-1] != 2) begin
        n_fail++;
        $display("FAIL full_get_spacing: gap %0d is %0d cycles, required 2", i, get_cyc[i] - get_cyc[i-1]);
      end
    end
    n_chk++;
    if (vld_cycles - v0 != 1) begin n_fail++; $display("FAIL full_blk_vld_len: got %0d cycles, required 1", vld_cycles - v0); end
    n_chk++;
    if (last_blk[DW-1:0] !== 32'h0000_0001) begin n_fail++; $display("FAIL full_word0: got %h, required 00000001", last_blk[DW-1:0]); end
    n_chk++;
    if (last_blk[BW-1 -: DW] !== 32'h0000_0022) begin n_fail++; $display("FAIL full_word33: got %h, required 00000022", last_blk[BW-1 -: DW]); end
    n_chk++;
    if (wcnt !== '0 || blk_vld !== 1'b0) begin n_fail++; $display("FAIL full_after: wcnt=%0d blk_vld=%0b, required 0 0", wcnt, blk_vld); end
  endtask

  task automatic test_hold();
    logic [BW-1:0] snap;
    int n;
    do_reset(2);
    lat = 1;
    for (int i = 1; i <= WORDS + 6; i++) fq.push_back(DW'(i));
    for (int i = 1; i <= WORDS; i++) exp_q.push_back(DW'(i));
    fifordy = 1'b1;
    n = 0;
    while (!blk_vld && n < 300) begin step(); n++; end
    n_chk++;
    if (blk_vld !== 1'b1) begin n_fail++; $display("FAIL hold_blk_vld_rise: got %0b, required 1", blk_vld); end
    snap = blk_data;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if (blk_vld !== 1'b1 || blk_data !== snap || fifoget !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d blk_vld=%0b data_same=%0b fifoget=%0b, required 1 1 0", i, blk_vld, blk_data === snap, fifoget);
      end
    end
    blk_rdy = 1'b1;
    step();
    n_chk++;
    if (blk_vld !== 1'b0 || wcnt !== '0) begin n_fail++; $display("FAIL hold_accept: blk_vld=%0b wcnt=%0d, required 0 0", blk_vld, wcnt); end
  endtask

  task automatic test_fifordy_pause();
    int g0, b0;
    logic [DW-1:0] w;
    do_reset(2);
    lat = 1;
    blk_rdy = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      w = $urandom;
      fq.push_back(w);
      exp_q.push_back(w);
    end
    fifordy = 1'b1;
    g0 = get_cnt; b0 = blk_cnt;
    run_until_gets(g0 + 5, 100, "pause");
    rdy_en = 1'b0;
    fifordy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++;
      if (wcnt !== CW'(5) || fifoget !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold: cycle %0d wcnt=%0d fifoget=%0b, required 5 0", i, wcnt, fifoget);
      end
    end
    rdy_en = 1'b1;
    fifordy = fq.size() > 0;
    run_until_blocks(b0 + 1, 300, "pause");
  endtask

  task automatic test_flush();
    int g0, b0;
    logic [DW-1:0] w[WORDS + 11];
    do_reset(2);
    lat = 3;
    blk_rdy = 1'b1;
    for (int i = 0; i < WORDS + 11; i++) begin
      w[i] = (i == 10) ? 32'hDEAD_BEEF : DW'($urandom);
      fq.push_back(w[i]);
      if (i >= 11) exp_q.push_back(w[i]);
    end
    fifordy = 1'b1;
    g0 = get_cnt; b0 = blk_cnt;
    run_until_gets(g0 + 11, 200, "flush");
    n_chk++;
    if (wcnt !== CW'(10)) begin n_fail++; $display("FAIL flush_pre_wcnt: got %0d, required 10", wcnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++;
    if (wcnt !== '0 || blk_vld !== 1'b0) begin n_fail++; $display("FAIL flush_clear: wcnt=%0d blk_vld=%0b, required 0 0", wcnt, blk_vld); end
    repeat (4) step();
    n_chk++;
    if (rderr !== 1'b0) begin n_fail++; $display("FAIL flush_rderr: got %0b, required 0", rderr); end
    run_until_blocks(b0 + 1, 400, "flush");
    n_chk++;
    if (rderr !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL flush_after: rderr=%0b left=%0d, required 0 0", rderr, exp_q.size()); end
  endtask

  task automatic test_spurious();
    do_reset(2);
    inj_word = 32'hA5A5_A5A5;
    inj_vld = 1'b1;
    step();
    step();
    n_chk++;
    if (rderr !== 1'b1) begin n_fail++; $display("FAIL spurious_rderr: got %0b, required 1", rderr); end
    n_chk++;
    if (wcnt !== '0 || blk_data !== '0) begin n_fail++; $display("FAIL spurious_packed: wcnt=%0d word0=%h, required 0 00000000", wcnt, blk_data[DW-1:0]); end
    repeat (6) step();
    n_chk++;
    if (rderr !== 1'b1) begin n_fail++; $display("FAIL spurious_sticky: got %0b, required 1", rderr); end
    do_reset(1);
    n_chk++;
    if (rderr !== 1'b0) begin n_fail++; $display("FAIL spurious_clear: got %0b, required 0", rderr); end
  endtask

  task automatic test_reset_midop();
    int g0;
    do_reset(2);
    lat = 4;
    for (int i = 0; i < WORDS; i++) fq.push_back(DW'($urandom));
    fifordy = 1'b1;
    g0 = get_cnt;
    run_until_gets(g0 + 3, 100, "midop");
    do_reset(1);
    g0 = get_cnt;
    repeat (6) step();
    n_chk++;
    if (rderr !== 1'b0) begin n_fail++; $display("FAIL midop_rderr: got %0b, required 0", rderr); end
    n_chk++;
    if (wcnt !== '0 || blk_data !== '0 || get_cnt != g0) begin
      n_fail++;
      $display("FAIL midop_state: wcnt=%0d word0=%h gets=%0d, required 0 00000000 0", wcnt, blk_data[DW-1:0], get_cnt - g0);
    end
  endtask

  task automatic test_random();
    int b0, n;
    logic [DW-1:0] w;
    do_reset(2);
    for (int i = 0; i < 3 * WORDS; i++) begin
      w = $urandom;
      fq.push_back(w);
      exp_q.push_back(w);
    end
    b0 = blk_cnt;
    n = 0;
    while (blk_cnt < b0 + 3 && n < 4000) begin
      rdy_en  = $urandom_range(0, 3) != 0;
      blk_rdy = $urandom_range(0, 1);
      lat     = 1 + $urandom_range(0, 3);
      step();
      n++;
    end
    n_chk++;
    if (blk_cnt != b0 + 3) begin n_fail++; $display("FAIL random_blocks: got %0d, required 3", blk_cnt - b0); end
    n_chk++;
    if (rderr !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL random_end: rderr=%0b left=%0d, required 0 0", rderr, exp_q.size()); end
  endtask

`ifdef FIFORD_TMO_EN
  task automatic test_timeout();
    int g0;
    logic [DW-1:0] slot2;
    do_reset(2);
    lat = 1;
    for (int i = 0; i < 3; i++) fq.push_back(DW'(i + 1));
    fifordy = 1'b1;
    g0 = get_cnt;
    run_until_gets(g0 + 2, 50, "tmo");
    no_resp = 1'b1;
    run_until_gets(g0 + 3, 50, "tmo");
    slot2 = blk_data[2*DW +: DW];
    repeat (14) step();
    n_chk++;
    if (rderr !== 1'b0 || wcnt !== CW'(2)) begin n_fail++; $display("FAIL tmo_early: rderr=%0b wcnt=%0d, required 0 2", rderr, wcnt); end
    step();
    n_chk++;
    if (rderr !== 1'b1 || wcnt !== CW'(2)) begin n_fail++; $display("FAIL tmo_expire: rderr=%0b wcnt=%0d, required 1 2", rderr, wcnt); end
    repeat (3) step();
    inj_word = 32'h0BAD_0BAD;
    inj_vld = 1'b1;
    step();
    step();
    n_chk++;
    if (wcnt !== CW'(2) || blk_data[2*DW +: DW] !== slot2 || blk_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_late_vld: wcnt=%0d slot2=%h blk_vld=%0b, required 2 %h 0", wcnt, blk_data[2*DW +: DW], blk_vld, slot2);
    end
    no_resp = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge rdclk);
    test_reset();
    test_full_block();
    test_hold();
    test_fifordy_pause();
    test_flush();
    test_spurious();
    test_reset_midop();
    test_random();
`ifdef FIFORD_TMO_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
